// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles every bus signal around the data-memory arbiter:
//   - port 0 / port 1 request side: req, we, addr, wdata in; ack, rdata, err out
//   - memory side: mem_addr, mem_we, mem_wdata out; mem_rdata, mem_error in
//   - busy status out
// Modports:
//   slave  : the arbiter itself
//   master : whoever surrounds it (pipeline stages, memory, bench)
// ----------------------------------------------------------------------------
interface dmem_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [63:0] p0_addr;
    logic [63:0] p0_wdata;
    logic        p0_ack;
    logic [63:0] p0_rdata;
    logic        p0_err;

    logic        p1_req;
    logic        p1_we;
    logic [63:0] p1_addr;
    logic [63:0] p1_wdata;
    logic        p1_ack;
    logic [63:0] p1_rdata;
    logic        p1_err;

    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_error;

    logic        busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rdata, p1_err,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata, mem_error,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata, p1_err,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata, mem_error,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter/sequencer in front of the single-ported 64-bit data memory.
// Each access runs IDLE -> ACCESS -> DONE: the winner's request is latched in
// IDLE, the memory is driven for exactly one ACCESS cycle, and the captured
// read data / error are returned with a one-cycle ack in DONE.
//
// Ports:
//   clk    in  system clock, all state on posedge
//   rst_n  in  synchronous active-low reset
//   bus    dmem_arbiter_if.slave (p0_*/p1_* request ports, mem_* memory
//          side, busy = high in ACCESS and DONE)
// Parameters:
//   ADDR_LIMIT   first illegal byte address (rejected with err, never written)
//   STARVE_LIMIT consecutive port-0 losses after which port 0 is forced to win
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                   undefined -> port 1 priority with port-0 starvation guard
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned ADDR_LIMIT   = 1024,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    localparam logic [63:0] ADDR_LIMIT_W = 64'(ADDR_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;

    logic        grant_s;
    logic        win_s;
    logic        win_we_s;
    logic [63:0] win_addr_s;
    logic [63:0] win_wdata_s;
    logic        win_in_range_s;
    logic        lat_in_range_s;

    logic        id_r;
    logic [63:0] addr_r;
    logic [63:0] wdata_r;
    logic        mem_we_r;
    logic        busy_r;
    logic        p0_ack_r;
    logic        p1_ack_r;
    logic [63:0] p0_rdata_r;
    logic [63:0] p1_rdata_r;
    logic        p0_err_r;
    logic        p1_err_r;

`ifdef DMEM_ARB_RR_EN
    logic        last_grant_r;
`else
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    logic [STARVE_W-1:0] starve_cnt_r;
`endif

    assign lat_in_range_s = (addr_r < ADDR_LIMIT_W);

    // Winner selection and mux of the winning port's request fields.
    always_comb begin
        grant_s        = 1'b0;
        win_s          = 1'b0;
        win_we_s       = 1'b0;
        win_addr_s     = 64'd0;
        win_wdata_s    = 64'd0;
        win_in_range_s = 1'b0;

        if (state_r == ST_IDLE) begin
            grant_s = bus.p0_req | bus.p1_req;
        end else begin
            grant_s = 1'b0;
        end

        if (bus.p0_req && bus.p1_req) begin
`ifdef DMEM_ARB_RR_EN
            // the port that did not win last time goes first
            win_s = ~last_grant_r;
`else
            // port 1 has priority unless port 0 has lost too often in a row
            win_s = (starve_cnt_r == STARVE_MAX) ? 1'b0 : 1'b1;
`endif
        end else begin
            win_s = bus.p1_req;
        end

        if (win_s) begin
            win_we_s    = bus.p1_we;
            win_addr_s  = bus.p1_addr;
            win_wdata_s = bus.p1_wdata;
        end else begin
            win_we_s    = bus.p0_we;
            win_addr_s  = bus.p0_addr;
            win_wdata_s = bus.p0_wdata;
        end

        win_in_range_s = (win_addr_s < ADDR_LIMIT_W);
    end

    // Next-state logic of the IDLE/ACCESS/DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_s = ST_DONE;
            ST_DONE:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch the granted request, drive memory for one cycle, capture the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_r       <= 1'b0;
            addr_r     <= 64'd0;
            wdata_r    <= 64'd0;
            mem_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            p0_ack_r   <= 1'b0;
            p1_ack_r   <= 1'b0;
            p0_rdata_r <= 64'd0;
            p1_rdata_r <= 64'd0;
            p0_err_r   <= 1'b0;
            p1_err_r   <= 1'b0;
        end else begin
            // grant_s is only ever high in IDLE, so mem_we_r lives for
            // exactly the ACCESS cycle; addr/wdata hold between accesses
            if (grant_s) begin
                id_r     <= win_s;
                addr_r   <= win_addr_s;
                wdata_r  <= win_wdata_s;
                mem_we_r <= win_we_s & win_in_range_s;
            end else begin
                mem_we_r <= 1'b0;
            end

            busy_r <= (state_s != ST_IDLE);

            // result registers are non-zero only during DONE, for the winner
            if (state_r == ST_ACCESS) begin
                p0_ack_r   <= ~id_r;
                p1_ack_r   <= id_r;
                p0_rdata_r <= id_r ? 64'd0 : bus.mem_rdata;
                p1_rdata_r <= id_r ? bus.mem_rdata : 64'd0;
                p0_err_r   <= ~id_r & (bus.mem_error | ~lat_in_range_s);
                p1_err_r   <= id_r & (bus.mem_error | ~lat_in_range_s);
            end else begin
                p0_ack_r   <= 1'b0;
                p1_ack_r   <= 1'b0;
                p0_rdata_r <= 64'd0;
                p1_rdata_r <= 64'd0;
                p0_err_r   <= 1'b0;
                p1_err_r   <= 1'b0;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Remember who won the most recent grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (grant_s) begin
            last_grant_r <= win_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    // Count consecutive port-0 losses, saturating; any port-0 grant clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (grant_s && !win_s) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (grant_s && bus.p0_req && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`endif

    // mem_we is also gated by rst_n so a reset cycle can never write memory
    assign bus.mem_we    = mem_we_r & rst_n;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.busy      = busy_r;
    assign bus.p0_ack    = p0_ack_r;
    assign bus.p1_ack    = p1_ack_r;
    assign bus.p0_rdata  = p0_rdata_r;
    assign bus.p1_rdata  = p1_rdata_r;
    assign bus.p0_err    = p0_err_r;
    assign bus.p1_err    = p1_err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter: a small array memory sits on the mem_*
// side, two request agents drive the ports from operation queues, and a
// transaction-level reference model predicts every output each cycle.
// Directed scenarios pin the model with literal expectations, then a
// randomized phase (random ports, addresses, gaps, in-flight input changes and
// reset pulses) runs against the model.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam logic [63:0] OOB_DATA = 64'hDEAD_BEEF_0BAD_F00D;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } op_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          at;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_clear;

    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(.ADDR_LIMIT(1024), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // behavioural single-ported memory: async read, write on posedge
    logic [63:0] mem_model [0:1023];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem_model[i] <= 64'd0;
        end else if (bus.mem_we === 1'b1 && bus.mem_addr < 64'd1024) begin
            mem_model[bus.mem_addr[9:0]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = (bus.mem_addr < 64'd1024) ? mem_model[bus.mem_addr[9:0]] : OOB_DATA;
    assign bus.mem_error = (bus.mem_addr >= 64'd1000) && (bus.mem_addr < 64'd1024);

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // agent state
    op_t  q0[$];
    op_t  q1[$];
    res_t r0[$];
    res_t r1[$];
    bit   act0 = 1'b0, act1 = 1'b0;
    bit   ack0_seen = 1'b0, ack1_seen = 1'b0;
    int   st0 = 0, st1 = 0;
    int   ncyc = 0;
    int   we_cycles = 0;
    int   start_pct = 100;
    bit   scramble = 1'b0;
    bit   rnd_rst = 1'b0;

    // reference model state
    bit          model_valid = 1'b0;
    int          ph = 0;
    logic        cur_id, cur_we;
    logic [63:0] cur_addr, cur_wdata;
    logic [63:0] gmem [0:1023];
    logic        e_ack0, e_ack1, e_err0, e_err1, e_busy;
    logic [63:0] e_rd0, e_rd1, e_maddr, e_mwdata;
`ifdef DMEM_ARB_RR_EN
    logic        lastg;
`else
    int          loss;
`endif

    // compare, monitor and model advance, all on the falling edge
    initial begin : compare_proc
        logic        w, inr, ev;
        logic [63:0] rv;
        res_t        rs;
        for (int i = 0; i < 1024; i++) gmem[i] = 64'd0;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                chk("p0_ack", bus.p0_ack, e_ack0);
                chk("p1_ack", bus.p1_ack, e_ack1);
                chk("p0_rdata", bus.p0_rdata, e_rd0);
                chk("p1_rdata", bus.p1_rdata, e_rd1);
                chk("p0_err", bus.p0_err, e_err0);
                chk("p1_err", bus.p1_err, e_err1);
                chk("busy", bus.busy, e_busy);
                chk("mem_addr", bus.mem_addr, e_maddr);
                chk("mem_wdata", bus.mem_wdata, e_mwdata);
                chk("mem_we", bus.mem_we,
                    (ph == 1 && cur_we && cur_addr < 64'd1024 && rst_n === 1'b1) ? 64'd1 : 64'd0);
            end
            if (bus.p0_ack === 1'b1) begin
                ack0_seen = 1'b1;
                rs.rdata = bus.p0_rdata; rs.err = bus.p0_err; rs.lat = ncyc - st0; rs.at = ncyc;
                r0.push_back(rs);
            end
            if (bus.p1_ack === 1'b1) begin
                ack1_seen = 1'b1;
                rs.rdata = bus.p1_rdata; rs.err = bus.p1_err; rs.lat = ncyc - st1; rs.at = ncyc;
                r1.push_back(rs);
            end
            if (bus.mem_we === 1'b1) we_cycles++;
            ncyc++;

            // predict what the outputs must be after the coming posedge
            if (rst_n !== 1'b1) begin
                ph = 0; model_valid = 1'b1;
                cur_id = 1'b0; cur_we = 1'b0; cur_addr = 64'd0; cur_wdata = 64'd0;
                e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0; e_busy = 1'b0;
                e_rd0 = 64'd0; e_rd1 = 64'd0; e_maddr = 64'd0; e_mwdata = 64'd0;
`ifdef DMEM_ARB_RR_EN
                lastg = 1'b1;
`else
                loss = 0;
`endif
            end else if (model_valid) begin
                e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
                e_rd0 = 64'd0; e_rd1 = 64'd0;
                if (ph == 0) begin
                    if (bus.p0_req || bus.p1_req) begin
`ifdef DMEM_ARB_RR_EN
                        if (bus.p0_req && bus.p1_req) w = ~lastg;
                        else w = bus.p1_req;
                        lastg = w;
`else
                        if (bus.p0_req && bus.p1_req) w = (loss >= 4) ? 1'b0 : 1'b1;
                        else w = bus.p1_req;
                        if (!w) loss = 0;
                        else if (bus.p0_req) loss = (loss < 4) ? loss + 1 : 4;
`endif
                        cur_id    = w;
                        cur_we    = w ? bus.p1_we : bus.p0_we;
                        cur_addr  = w ? bus.p1_addr : bus.p0_addr;
                        cur_wdata = w ? bus.p1_wdata : bus.p0_wdata;
                        e_maddr = cur_addr; e_mwdata = cur_wdata;
                        e_busy = 1'b1; ph = 1;
                    end else begin
                        e_busy = 1'b0;
                    end
                end else if (ph == 1) begin
                    inr = (cur_addr < 64'd1024);
                    rv  = inr ? gmem[cur_addr[9:0]] : OOB_DATA;
                    ev  = !inr || (cur_addr >= 64'd1000);
                    if (inr && cur_we) gmem[cur_addr[9:0]] = cur_wdata;
                    if (cur_id) begin e_ack1 = 1'b1; e_rd1 = rv; e_err1 = ev; end
                    else begin e_ack0 = 1'b1; e_rd0 = rv; e_err0 = ev; end
                    e_busy = 1'b1; ph = 2;
                end else begin
                    e_busy = 1'b0; ph = 0;
                end
            end
        end
    end

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        case ($urandom_range(9, 0))
            0, 1, 2, 3, 4, 5: a = 64'($urandom_range(31, 0));
            6:       a = 64'($urandom_range(1023, 1000));
            7:       a = 64'($urandom_range(1030, 1020));
            8:       a = {$urandom, $urandom};
            default: a = 64'd1024;
        endcase
        return a;
    endfunction

    task automatic push_op(input bit port, input bit we, input logic [63:0] addr, input logic [63:0] wdata);
        op_t op;
        op.we = we; op.addr = addr; op.wdata = wdata;
        if (port) q1.push_back(op);
        else q0.push_back(op);
    endtask

    // one clock: agents drop req the cycle after ack, then start queued ops
    task automatic step();
        op_t op;
        @(posedge clk); #1;
        if (rnd_rst) rst_n = ($urandom_range(149, 0) == 0) ? 1'b0 : 1'b1;
        if (act0 && ack0_seen) begin act0 = 1'b0; bus.p0_req = 1'b0; end
        ack0_seen = 1'b0;
        if (!act0 && q0.size() > 0 && $urandom_range(99, 0) < start_pct) begin
            op = q0.pop_front(); act0 = 1'b1; st0 = ncyc;
            bus.p0_req = 1'b1; bus.p0_we = op.we; bus.p0_addr = op.addr; bus.p0_wdata = op.wdata;
        end else if (scramble && $urandom_range(3, 0) == 0) begin
            bus.p0_we = 1'($urandom_range(1, 0)); bus.p0_addr = rand_addr(); bus.p0_wdata = {$urandom, $urandom};
        end
        if (act1 && ack1_seen) begin act1 = 1'b0; bus.p1_req = 1'b0; end
        ack1_seen = 1'b0;
        if (!act1 && q1.size() > 0 && $urandom_range(99, 0) < start_pct) begin
            op = q1.pop_front(); act1 = 1'b1; st1 = ncyc;
            bus.p1_req = 1'b1; bus.p1_we = op.we; bus.p1_addr = op.addr; bus.p1_wdata = op.wdata;
        end else if (scramble && $urandom_range(3, 0) == 0) begin
            bus.p1_we = 1'($urandom_range(1, 0)); bus.p1_addr = rand_addr(); bus.p1_wdata = {$urandom, $urandom};
        end
    endtask

    task automatic drain(input string name, input int limit);
        int guard = 0;
        while ((q0.size() > 0 || q1.size() > 0 || act0 || act1) && guard < limit) begin
            step();
            guard++;
        end
        chk(name, (guard >= limit) ? 64'd1 : 64'd0, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        act0 = 1'b0; act1 = 1'b0; ack0_seen = 1'b0; ack1_seen = 1'b0;
        q0.delete(); q1.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int   w0, n;
        res_t a, b;

        rst_n = 1'b0; mem_clear = 1'b1;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 64'd0; bus.p0_wdata = 64'd0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 64'd0; bus.p1_wdata = 64'd0;
        @(posedge clk); #1 mem_clear = 1'b0;
        @(posedge clk); #1;
        chk("rst_p0_ack", bus.p0_ack, 64'd0);
        chk("rst_p1_ack", bus.p1_ack, 64'd0);
        chk("rst_p0_err", bus.p0_err, 64'd0);
        chk("rst_p1_err", bus.p1_err, 64'd0);
        chk("rst_busy", bus.busy, 64'd0);
        chk("rst_mem_we", bus.mem_we, 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        rst_n = 1'b1;
        repeat (5) begin
            step();
            chk("idle_busy", bus.busy, 64'd0);
        end

        // p1 write 10 <- 100, then read it back
        w0 = we_cycles;
        push_op(1'b1, 1'b1, 64'd10, 64'd100);
        drain("drain_wr", 50);
        a = r1[r1.size() - 1];
        chk("wr_we_cycles", 64'(we_cycles - w0), 64'd1);
        chk("wr_latency", 64'(a.lat), 64'd2);
        chk("wr_err", a.err, 64'd0);
        w0 = we_cycles;
        push_op(1'b1, 1'b0, 64'd10, 64'd0);
        drain("drain_rd", 50);
        a = r1[r1.size() - 1];
        chk("rd_data", a.rdata, 64'd100);
        chk("rd_err", a.err, 64'd0);
        chk("rd_we_cycles", 64'(we_cycles - w0), 64'd0);

        // simultaneous requests
        r0.delete(); r1.delete();
        push_op(1'b0, 1'b0, 64'd10, 64'd0);
        push_op(1'b1, 1'b1, 64'd19, 64'd10);
        drain("drain_simul", 50);
        a = r0[0]; b = r1[0];
`ifdef DMEM_ARB_RR_EN
        chk("simul_order", 64'(b.at), 64'(a.at + 3));
`else
        chk("simul_order", 64'(a.at), 64'(b.at + 3));
`endif
        chk("simul_p0_rdata", a.rdata, 64'd100);

        // starvation guard / round-robin alternation
        do_reset();
        r0.delete(); r1.delete();
        push_op(1'b0, 1'b0, 64'd19, 64'd0);
        push_op(1'b0, 1'b0, 64'd19, 64'd0);
        for (int i = 0; i < 6; i++) push_op(1'b1, 1'b1, 64'(20 + i), 64'(i));
        drain("drain_starve", 200);
        n = 0;
        foreach (r1[i]) if (r1[i].at < r0[0].at) n++;
`ifdef DMEM_ARB_RR_EN
        chk("starve_first_p0", 64'(n), 64'd0);
`else
        chk("starve_first_p0", 64'(n), 64'd4);
`endif
        n = 0;
        foreach (r1[i]) if (r1[i].at < r0[1].at) n++;
`ifdef DMEM_ARB_RR_EN
        chk("starve_second_p0", 64'(n), 64'd1);
`else
        chk("starve_second_p0", 64'(n), 64'd6);
`endif
        chk("starve_p0_rdata", r0[0].rdata, 64'd10);

        // out-of-range write is rejected, memory untouched
        r0.delete(); r1.delete();
        w0 = we_cycles;
        push_op(1'b0, 1'b1, 64'd96, 64'd55);
        push_op(1'b0, 1'b1, 64'd1024, 64'd90);
        push_op(1'b0, 1'b0, 64'd96, 64'd0);
        push_op(1'b0, 1'b0, 64'd1024, 64'd0);
        drain("drain_oob", 100);
        chk("oob_wr_ok_err", r0[0].err, 64'd0);
        chk("oob_wr_err", r0[1].err, 64'd1);
        chk("oob_wr_latency", 64'(r0[1].lat), 64'd2);
        chk("oob_rd96_data", r0[2].rdata, 64'd55);
        chk("oob_rd96_err", r0[2].err, 64'd0);
        chk("oob_rd_err", r0[3].err, 64'd1);
        chk("oob_we_cycles", 64'(we_cycles - w0), 64'd1);
        push_op(1'b1, 1'b0, 64'd1000, 64'd0);
        push_op(1'b1, 1'b0, 64'd999, 64'd0);
        drain("drain_memerr", 50);
        chk("memerr_pass", r1[0].err, 64'd1);
        chk("memerr_clear", r1[1].err, 64'd0);

        // reset in the ACCESS cycle of a p1 write to 96
        r1.delete();
        push_op(1'b1, 1'b1, 64'd96, 64'd77);
        step();
        step();
        chk("mid_busy", bus.busy, 64'd1);
        rst_n = 1'b0;
        bus.p1_req = 1'b0; act1 = 1'b0;
        #1;
        chk("mid_rst_mem_we", bus.mem_we, 64'd0);
        @(posedge clk); #1;
        chk("mid_rst_busy", bus.busy, 64'd0);
        chk("mid_rst_ack", bus.p1_ack, 64'd0);
        rst_n = 1'b1;
        repeat (4) step();
        chk("mid_rst_no_ack", 64'(r1.size()), 64'd0);
        push_op(1'b1, 1'b0, 64'd96, 64'd0);
        drain("drain_mid", 50);
        chk("mid_rd96", r1[0].rdata, 64'd55);

        // randomized traffic against the model
        r0.delete(); r1.delete();
        start_pct = 60; scramble = 1'b1; rnd_rst = 1'b1;
        n = 0;
        for (int c = 0; c < 3000 && n < 400; c++) begin
            if ($urandom_range(1, 0) == 0 && q0.size() < 2) begin
                push_op(1'b0, 1'($urandom_range(1, 0)), rand_addr(), {$urandom, $urandom});
                n++;
            end
            if ($urandom_range(1, 0) == 0 && q1.size() < 2) begin
                push_op(1'b1, 1'($urandom_range(1, 0)), rand_addr(), {$urandom, $urandom});
                n++;
            end
            step();
        end
        rnd_rst = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        start_pct = 100;
        drain("drain_random", 300);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
